// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared types and helpers for the Gray-code step monitor.
//   state_e      : monitor FSM states (EMPTY = no reference sample yet)
//   gray2bin()   : Gray-to-binary decode on a GRAY_MAX_W-wide word; narrower
//                  codes are zero-extended, which leaves their low bits exact
//   DELTA_UP/DN  : binary deltas of the legal single steps (slice to width W)
// -----------------------------------------------------------------------------
package gray_pkg;

   // Widest Gray word the helper function handles.
   localparam int GRAY_MAX_W = 32;

   // A +1 step and a -1 step (all ones, i.e. -1 modulo 2^W after slicing).
   localparam logic [GRAY_MAX_W-1:0] DELTA_UP = GRAY_MAX_W'(1);
   localparam logic [GRAY_MAX_W-1:0] DELTA_DN = '1;

   typedef enum logic {
      EMPTY = 1'b0,
      TRACK = 1'b1
   } state_e;

   // bin[i] is the XOR of all Gray bits at or above i. Zero bits above the
   // real width contribute nothing, so one function serves any W <= max.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage : gray_pkg

// File: rtl/gray2bin_comb.sv
// -----------------------------------------------------------------------------
// gray2bin_comb
// Purely combinational W-bit Gray-to-binary decoder.
// Ports:
//   g : input  [W-1:0]  Gray code
//   b : output [W-1:0]  decoded binary
// W must not exceed gray_pkg::GRAY_MAX_W.
// -----------------------------------------------------------------------------
module gray2bin_comb
   import gray_pkg::*;
#(
   parameter int W = 3
) (
   input  logic [W-1:0] g,
   output logic [W-1:0] b
);

   logic [GRAY_MAX_W-1:0] b_full;

   always_comb begin
      b_full = gray2bin(GRAY_MAX_W'(g));
   end

   assign b = b_full[W-1:0];

endmodule : gray2bin_comb

// File: rtl/gray_step_monitor.sv
// -----------------------------------------------------------------------------
// gray_step_monitor
// Samples a Gray code on g_valid, decodes it and classifies the binary step
// against the previous accepted sample (hold, +1, -1 modulo 2^W, or error).
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   g_in         : [W-1:0] Gray code from the upstream converter
//   g_valid      : g_in is sampled this cycle
//   clr_err      : synchronous clear of err_sticky / err_count
//   b_out        : [W-1:0] decoded binary of the last accepted sample
//   out_valid    : one-cycle pulse, b_out and classification updated
//   step_up/step_dn/hold/step_err : classification pulses (with out_valid)
//   err_sticky   : set by any step_err until clr_err or reset
//   err_count    : [CW-1:0] saturating count of step_err events
// -----------------------------------------------------------------------------
module gray_step_monitor
   import gray_pkg::*;
#(
   parameter int W  = 3,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  g_in,
   input  logic          g_valid,
   input  logic          clr_err,
   output logic [W-1:0]  b_out,
   output logic          out_valid,
   output logic          step_up,
   output logic          step_dn,
   output logic          hold,
   output logic          step_err,
   output logic          err_sticky,
   output logic [CW-1:0] err_count
);

   localparam logic [W-1:0]  D_UP    = DELTA_UP[W-1:0];
   localparam logic [W-1:0]  D_DN    = DELTA_DN[W-1:0];
   localparam logic [CW-1:0] CNT_MAX = '1;

   state_e        state_q,      state_d;
   logic [W-1:0]  prev_q,       prev_d;
   logic          out_valid_q,  out_valid_d;
   logic          step_up_q,    step_up_d;
   logic          step_dn_q,    step_dn_d;
   logic          hold_q,       hold_d;
   logic          step_err_q,   step_err_d;
   logic          err_sticky_q, err_sticky_d;
   logic [CW-1:0] err_count_q,  err_count_d;

   logic [W-1:0]  bin;
   logic [W-1:0]  delta;

   gray2bin_comb #(.W(W)) u_dec (
      .g (g_in),
      .b (bin)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d      = state_q;
      prev_d       = prev_q;
      out_valid_d  = 1'b0;
      step_up_d    = 1'b0;
      step_dn_d    = 1'b0;
      hold_d       = 1'b0;
      step_err_d   = 1'b0;
      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
      delta        = bin - prev_q;

      if (g_valid) begin
         out_valid_d = 1'b1;
         prev_d      = bin;
         case (state_q)
            EMPTY: state_d = TRACK;   // first sample only becomes the reference
            TRACK: begin
               if (delta == '0)        hold_d     = 1'b1;
               else if (delta == D_UP) step_up_d  = 1'b1;
               else if (delta == D_DN) step_dn_d  = 1'b1;
               else                    step_err_d = 1'b1;
            end
            default: state_d = EMPTY;
         endcase
      end

      // Clear is applied before this cycle's error, so a coincident error
      // still leaves count = 1 and sticky set.
      if (clr_err) begin
         err_sticky_d = 1'b0;
         err_count_d  = '0;
      end
      if (step_err_d) begin
         err_sticky_d = 1'b1;
         if (err_count_d != CNT_MAX) err_count_d = err_count_d + CW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         prev_q       <= '0;
         out_valid_q  <= 1'b0;
         step_up_q    <= 1'b0;
         step_dn_q    <= 1'b0;
         hold_q       <= 1'b0;
         step_err_q   <= 1'b0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         out_valid_q  <= out_valid_d;
         step_up_q    <= step_up_d;
         step_dn_q    <= step_dn_d;
         hold_q       <= hold_d;
         step_err_q   <= step_err_d;
         err_sticky_q <= err_sticky_d;
         err_count_q  <= err_count_d;
      end
   end

   // The reference sample is also the reported value.
   assign b_out      = prev_q;
   assign out_valid  = out_valid_q;
   assign step_up    = step_up_q;
   assign step_dn    = step_dn_q;
   assign hold       = hold_q;
   assign step_err   = step_err_q;
   assign err_sticky = err_sticky_q;
   assign err_count  = err_count_q;

endmodule : gray_step_monitor

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Downstream consumer of the binary-to-Gray converter stage: samples a W-bit Gray code each valid cycle, decodes it back to binary and classifies each transition against the previous accepted sample.
- Legal transitions are hold, +1 or −1 modulo 2^W. Anything else is a step error.
- Provides the registered binary value, direction pulses, a sticky error flag and a saturating error counter for bring-up and self-check of the converter path.

Parameters:
W, 3, Gray/binary word width (≥2)
CW, 8, error counter width (≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
g_in  in  W  Gray code from upstream converter
g_valid  in  1  g_in is sampled this cycle
clr_err  in  1  synchronous clear of err_sticky and err_count
b_out  out  W  decoded binary of last accepted sample
out_valid  out  1  one-cycle pulse: b_out and classification updated
step_up  out  1  pulse with out_valid: binary delta = +1 mod 2^W
step_dn  out  1  pulse with out_valid: binary delta = −1 mod 2^W
hold  out  1  pulse with out_valid: delta = 0
step_err  out  1  pulse with out_valid: delta not in {0,+1,−1}
err_sticky  out  1  set by any step_err, cleared only by clr_err or reset
err_count  out  CW  count of step_err events, saturates at 2^CW−1

Behaviour:
- Reset (async assert, sync-released by the system): all outputs 0, prev register 0, FSM = EMPTY.
- Decode: bin[W−1] = g[W−1]; bin[i] = bin[i+1] XOR g[i]. This is combinational on g_in.
- Latency: g_valid high at edge N → b_out, out_valid and the class pulses are valid after edge N (one register stage). Without g_valid, out_valid and all class pulses are 0 and b_out holds.
- FSM:
  - EMPTY: no reference sample. On g_valid: capture bin, out_valid=1, all class pulses 0, go to TRACK.
  - TRACK: on g_valid, delta = bin − prev (mod 2^W). delta 0 → hold; 1 → step_up; 2^W−1 → step_dn; otherwise step_err. prev ← bin regardless, then stay in TRACK.
- Exactly one of hold/step_up/step_dn/step_err is asserted with each out_valid in TRACK; none in EMPTY.
- Wrap-around: 2^W−1 → 0 is step_up; 0 → 2^W−1 is step_dn.
- Error count increments on step_err and saturates; no wrap at max.
- clr_err and step_err in the same cycle: clear takes effect first, so err_count=1 and err_sticky=1 afterwards. clr_err alone: count=0, sticky=0. clr_err does not affect the FSM or prev.
- Reset mid-stream: immediate return to EMPTY with outputs 0. The first sample after reset is never classified.
- g_in is don't-care when g_valid=0.

Decomposition:
- Shared package gray_pkg:
  - state enum {EMPTY, TRACK}
  - function gray2bin(W-generic)
  - localparams for delta codes (DELTA_UP=1, DELTA_DN=all-ones)
- Natural sub-module: gray2bin_comb, the purely combinational W-bit decoder, also reusable for bench checking.
- The classifier and counters stay in gray_step_monitor.

Test Plan:
1. W=3, g_valid every cycle, g_in = 000,001,011,010,110,111,101,100 → b_out 0..7. First out_valid has no class pulse; the next 7 give step_up; err_count=0.
2. Continue with 100→000 → b_out=0 and step_up (wrap). Then 000→100 → b_out=7 and step_dn.
3. Gray 000 then 011 (binary 0→2) → step_err=1, err_sticky=1, err_count=1. Repeat the same g_in → hold=1 and no new error.
4. CW=2 with 5 consecutive illegal jumps (000↔011 alternating) → err_count stops at 3. clr_err together with a 6th illegal jump → err_count=1, err_sticky=1.
5. g_valid gaps: sample 001, idle 3 cycles, sample 011 → out_valid only on the 2 sampled cycles. b_out holds 1 during the gap, then step_up to 2.
6. Assert rst_n=0 mid-sequence at b=5 → outputs 0 immediately. Release, then send 111 (binary 5) → out_valid with no class pulse (EMPTY), then TRACK.
